// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: FSM states, sampling
// offsets around the bit centre and the FIFO entry layout.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        STOP2
    } rx_state_t;

    localparam int unsigned MIN_WORD = 5;
    localparam int unsigned MAX_WORD = 15;

    // Majority samples sit at OVS/2-SMP_PRE, OVS/2 and OVS/2+SMP_POST.
    localparam int unsigned SMP_PRE  = 1;
    localparam int unsigned SMP_POST = 1;

    typedef struct packed {
        logic [MAX_WORD-1:0] data;
        logic                par_err;
        logic                frm_err;
    } uart_rx_entry_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Read-side handshake of the receive FIFO: head word, flags, valid/ready, level.
`timescale 1ns/1ps
interface uart_rx_fifo_if #(
    parameter int unsigned DATA_W     = 9,
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] rd_data;
    logic              rd_par_err;
    logic              rd_frm_err;
    logic              rd_valid;
    logic              rd_ready;
    logic [LVL_W-1:0]  fifo_level;

    modport master (
        output rd_data, rd_par_err, rd_frm_err, rd_valid, fifo_level,
        input  rd_ready
    );

    modport slave (
        input  rd_data, rd_par_err, rd_frm_err, rd_valid, fifo_level,
        output rd_ready
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Generic first-word-fall-through FIFO; head is read straight from storage and
// forced to zero while empty so the outputs never carry stale data.
`timescale 1ns/1ps
module uart_sync_fifo #(
    parameter  int unsigned WIDTH = 11,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level,
    output logic             push_ok,
    output logic             pop_ok
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign empty    = (level == '0);
    assign full     = (level == LW'(DEPTH));
    assign pop_ok   = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-point majority sampling feeding a FWFT receive FIFO.
// Optional UART_RX_BREAK_EN: all-zero frames raise uart_rx_brk_it instead of pushing.
`timescale 1ns/1ps
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = 9,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIV_W      = 9,
    parameter int unsigned OVS        = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [DIV_W-1:0] cfg_clk_div,
    input  logic             cfg_has_parity,
    input  logic             cfg_odd_parity,
    input  logic             cfg_extend_stop,
    input  logic             cfg_lsb_first,
    input  logic [3:0]       cfg_word,
    input  logic             ms_urx,
    uart_rx_fifo_if.master   rd,
    output logic             uart_rx_new_it,
    output logic             uart_rx_par_it,
    output logic             uart_rx_frm_it,
    output logic             uart_rx_ovr_it
`ifdef UART_RX_BREAK_EN
    ,
    output logic             uart_rx_brk_it
`endif
);
    localparam int unsigned TW = $clog2(OVS);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned S0 = OVS / 2 - SMP_PRE;
    localparam int unsigned S1 = OVS / 2;
    localparam int unsigned S2 = OVS / 2 + SMP_POST;
    localparam int unsigned EW = DATA_W + 2;

    function automatic logic [3:0] clamp_word(input logic [3:0] w);
        if (w < 4'(MIN_WORD)) return 4'(MIN_WORD);
        if (32'(w) > DATA_W) return 4'(DATA_W);
        return w;
    endfunction

    rx_state_t         state_q, state_d;
    logic              sync1, line, line_prev, lock_q;
    logic [DIV_W-1:0]  div_q, div_cnt;
    logic [TW-1:0]     tick_cnt;
    logic              has_par_q, odd_q, ext_q, lsb_q;
    logic [3:0]        word_q, bit_cnt, data_idx;
    logic              smp0, smp1, bit_maj;
    logic [DATA_W-1:0] data_q;
    logic              par_bit_q, frm_q, any_one_q, push_q, push_d;
    logic              tick, tick_s2, tick_last, start_edge, frm_next;
    logic              push_req, push_ok, pop_ok, full, empty;
    uart_rx_entry_t    entry;
    logic [EW-1:0]     head;
    logic [LW-1:0]     level;
    logic              unused_hi;

    assign tick       = (state_q != IDLE) && (div_cnt == div_q);
    assign tick_s2    = tick && (tick_cnt == TW'(S2));
    assign tick_last  = tick && (tick_cnt == TW'(OVS - 1));
    assign bit_maj    = maj3(smp0, smp1, line);
    assign start_edge = (state_q == IDLE) && line_prev && !line && !lock_q;
    assign frm_next   = frm_q | ~bit_maj;
    assign data_idx   = lsb_q ? bit_cnt : (word_q - 4'd1 - bit_cnt);

    always_comb begin
        state_d = state_q;
        push_d  = 1'b0;
        unique case (state_q)
            IDLE:   if (start_edge) state_d = START;
            START: begin
                if (tick_s2 && bit_maj) state_d = IDLE;
                else if (tick_last)     state_d = DATA;
            end
            DATA: begin
                if (tick_last && (bit_cnt == word_q - 4'd1))
                    state_d = has_par_q ? PARITY : STOP;
            end
            PARITY: if (tick_last) state_d = STOP;
            STOP: begin
                if (tick_s2 && !ext_q) begin
                    state_d = IDLE;
                    push_d  = 1'b1;
                end else if (tick_last) begin
                    state_d = STOP2;
                end
            end
            STOP2: begin
                if (tick_s2) begin
                    state_d = IDLE;
                    push_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sync1     <= 1'b1;
            line      <= 1'b1;
            line_prev <= 1'b1;
            lock_q    <= 1'b0;
            push_q    <= 1'b0;
            div_q     <= '0;
            div_cnt   <= '0;
            tick_cnt  <= '0;
            has_par_q <= 1'b0;
            odd_q     <= 1'b0;
            ext_q     <= 1'b0;
            lsb_q     <= 1'b0;
            word_q    <= 4'(MIN_WORD);
            bit_cnt   <= '0;
            smp0      <= 1'b1;
            smp1      <= 1'b1;
            data_q    <= '0;
            par_bit_q <= 1'b0;
            frm_q     <= 1'b0;
            any_one_q <= 1'b0;
        end else begin
            sync1     <= ms_urx;
            line      <= sync1;
            line_prev <= line;
            push_q    <= push_d;
            // Lock is raised together with the push so the push cycle is covered.
            if (push_d && frm_next) lock_q <= 1'b1;
            else if (line)          lock_q <= 1'b0;

            if (start_edge) begin
                div_q     <= cfg_clk_div;
                has_par_q <= cfg_has_parity;
                odd_q     <= cfg_odd_parity;
                ext_q     <= cfg_extend_stop;
                lsb_q     <= cfg_lsb_first;
                word_q    <= clamp_word(cfg_word);
                div_cnt   <= '0;
                tick_cnt  <= '0;
                bit_cnt   <= '0;
                data_q    <= '0;
                par_bit_q <= 1'b0;
                frm_q     <= 1'b0;
                any_one_q <= 1'b0;
            end else if (state_q != IDLE) begin
                if (tick) begin
                    div_cnt  <= '0;
                    tick_cnt <= (tick_cnt == TW'(OVS - 1)) ? '0 : tick_cnt + 1'b1;
                    if (tick_cnt == TW'(S0)) smp0 <= line;
                    if (tick_cnt == TW'(S1)) smp1 <= line;
                    if (tick_s2) begin
                        unique case (state_q)
                            DATA: begin
                                for (int unsigned i = 0; i < DATA_W; i++)
                                    if (4'(i) == data_idx) data_q[i] <= bit_maj;
                                any_one_q <= any_one_q | bit_maj;
                            end
                            PARITY: begin
                                par_bit_q <= bit_maj;
                                any_one_q <= any_one_q | bit_maj;
                            end
                            STOP, STOP2: begin
                                frm_q     <= frm_next;
                                any_one_q <= any_one_q | bit_maj;
                            end
                            default: ;
                        endcase
                    end
                    if (tick_last && (state_q == DATA)) bit_cnt <= bit_cnt + 1'b1;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        entry         = '0;
        entry.data    = MAX_WORD'(data_q);
        entry.par_err = has_par_q & ((^data_q ^ par_bit_q) != odd_q);
        entry.frm_err = frm_q;
    end
    assign unused_hi = ^entry.data[MAX_WORD-1:DATA_W];

`ifdef UART_RX_BREAK_EN
    assign push_req       = push_q && any_one_q;
    assign uart_rx_brk_it = push_q && !any_one_q;
`else
    logic unused_any;
    assign unused_any = any_one_q;
    assign push_req   = push_q;
`endif

    uart_sync_fifo #(
        .WIDTH(EW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rstb),
        .push     (push_req),
        .push_data({entry.data[DATA_W-1:0], entry.par_err, entry.frm_err}),
        .pop      (rd.rd_ready),
        .pop_data (head),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .push_ok  (push_ok),
        .pop_ok   (pop_ok)
    );

    assign rd.rd_data    = head[EW-1:2];
    assign rd.rd_par_err = head[1];
    assign rd.rd_frm_err = head[0];
    assign rd.rd_valid   = !empty;
    assign rd.fifo_level = level;

    assign uart_rx_new_it = push_ok;
    assign uart_rx_par_it = push_ok && entry.par_err;
    assign uart_rx_frm_it = push_ok && entry.frm_err;
    assign uart_rx_ovr_it = push_req && !push_ok;
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised next-generation UART receiver with an integrated receive FIFO.
- Deserialises `ms_urx` using configurable word length (5..DATA_W bits), parity, stop length and bit order.
- Samples each bit with 3-point majority voting on an oversampled bit clock.
- Buffers words plus per-word error flags in a first-word-fall-through FIFO, read through a valid/ready handshake.
- Sits between the pad-side serial input and the register/DMA layer; replaces the single-register receiver.

Parameters:
- DATA_W, 9, maximum data bits per word; storage width.
- FIFO_DEPTH, 8, FIFO entries; must be a power of 2, at least 2.
- DIV_W, 9, width of `cfg_clk_div`.
- OVS, 8, oversample ticks per bit; must be even, at least 4.

Ports:
- clk  in  1  system clock
- rstb  in  1  asynchronous active-low reset
- cfg_clk_div  in  DIV_W  tick period = cfg_clk_div+1 clk cycles; bit period = OVS ticks
- cfg_has_parity  in  1  parity bit present
- cfg_odd_parity  in  1  1 = odd parity, 0 = even parity
- cfg_extend_stop  in  1  two stop bits
- cfg_lsb_first  in  1  1 = LSB first, 0 = MSB first
- cfg_word  in  4  data bits per word; values below 5 clamp to 5, above DATA_W clamp to DATA_W
- ms_urx  in  1  serial input, asynchronous to clk
- rd_data  out  DATA_W  FIFO head word, right-aligned, unused MSBs = 0
- rd_par_err  out  1  head word parity error flag
- rd_frm_err  out  1  head word framing error flag
- rd_valid  out  1  FIFO not empty
- rd_ready  in  1  pop head when rd_valid && rd_ready
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries stored
- uart_rx_new_it  out  1  1-cycle pulse: word pushed
- uart_rx_par_it  out  1  1-cycle pulse: pushed word has parity error
- uart_rx_frm_it  out  1  1-cycle pulse: pushed word has framing error
- uart_rx_ovr_it  out  1  1-cycle pulse: word dropped, FIFO full

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in IDLE, tick counter 0. Reset mid-frame aborts the frame and pushes nothing.
- Input path:
  - `ms_urx` passes through a 2-flop synchroniser whose flops reset to 1.
  - Tick generator pulses once every cfg_clk_div+1 clocks while the FSM is not IDLE. It restarts at the falling edge.
- Bit sampling: majority of 3 samples taken at ticks OVS/2-1, OVS/2 and OVS/2+1 within each bit.
- Configuration: all cfg_* are latched at start detection and held for the frame. Changes mid-frame take effect on the next frame.
- FSM:
  - IDLE: falling edge of synchronised line -> START. Start detection is disabled while `line_low_lock` is set.
  - START: majority = 1 -> IDLE (glitch rejected, no push). Majority = 0 -> DATA.
  - DATA: shift cfg_word bits. LSB-first: first bit -> bit0. MSB-first: first bit -> bit cfg_word-1. After the last bit -> PARITY if has_parity, else STOP.
  - PARITY: par_err = (XOR of data bits ^ parity bit) != cfg_odd_parity.
  - STOP: sample the stop bit. If extend_stop, -> STOP2, which samples the second stop bit. frm_err = any stop sample = 0.
  - Push cycle: the cycle after the final stop sample. Push {data, par_err, frm_err}, then -> IDLE. If frm_err, set `line_low_lock`; it clears when the synchronised line = 1.
- Interrupts:
  - On a successful push, `uart_rx_new_it` pulses, together with `par_it`/`frm_it` as flagged.
  - On a push while full, `ovr_it` pulses alone and the FIFO is unchanged.
- FIFO:
  - rd_* outputs reflect the head combinationally from storage; no read latency.
  - Simultaneous push and pop while full: pop happens, push is accepted, level unchanged, no overrun.
  - Simultaneous push and pop while empty: push only; rd_valid rises next cycle.
  - Pointers wrap modulo FIFO_DEPTH. fifo_level is 0..FIFO_DEPTH.
- With cfg_clk_div = 0, one tick per clk; must still function.

Optional Feature:
`UART_RX_BREAK_EN`
- Defined: break detection is enabled. A frame whose data, parity and stop samples are all 0 is not pushed. Instead, port `uart_rx_brk_it` (out, 1) pulses for one cycle in the push cycle, and `line_low_lock` is set.
- Undefined: the port is absent, and such a frame is pushed as data 0 with frm_err = 1.

Decomposition:
- Package `uart_pkg`:
  - rx FSM state enum (IDLE, START, DATA, PARITY, STOP, STOP2)
  - constants MIN_WORD = 5 and sample-tick offsets
  - packed struct `uart_rx_entry_t` {data, par_err, frm_err}
- Sub-module `uart_sync_fifo`: generic FWFT FIFO parametrised by entry width and depth, providing push/pop/full/empty/level. Reusable by the TX path.

Test Plan:
All scenarios use cfg_clk_div = 4 and OVS = 8.
- 8-bit, MSB-first, no parity, 1 stop; send 0xCA then 0x53 with rd_ready = 0 -> fifo_level = 2; rd_data 0x0CA then 0x53 after pops; 2 `new_it` pulses; no error pulses.
- 8-bit, LSB-first, even parity; send 0x41 with a correct parity bit, then 0xF8 with an inverted parity bit -> entry 0 par_err = 0; entry 1 par_err = 1 with a `par_it` pulse coinciding with `new_it`.
- 7-bit, LSB-first, extend_stop; send 0x50 with the second stop bit forced 0 -> rd_data = 0x050, frm_err = 1, `frm_it` pulse; no new start until the line returns high.
- rd_ready = 0; send 9 words 0x80, 0x81 .. 0x88 with FIFO_DEPTH = 8 -> level = 8; `ovr_it` on the 9th word; head = 0x80. With rd_ready held 1 during the 9th push -> no overrun, level stays 8.
- Idle line pulsed low for 6 clk (less than half a bit) -> no push, no interrupt, FSM back in IDLE. rstb asserted mid-DATA -> level 0, all outputs 0.
- `UART_RX_BREAK_EN`: hold the line low for 12 bit times -> one `uart_rx_brk_it` pulse, level unchanged. Without the macro -> one entry with data 0x000 and frm_err = 1.
